// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer that drives the m/set/en interface of the DDS core.
// Optional macro SWEEP_PINGPONG_EN makes the sweep bounce between the endpoints until aborted.
module dds_sweep_ctrl #(
  parameter int MW = 40,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [MW-1:0] f_start,
  input  logic [MW-1:0] f_stop,
  input  logic [MW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  output logic [MW-1:0] dds_m,
  output logic          dds_set,
  output logic          dds_en,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, DWELL, FINAL} state_t;

  localparam logic [DW-1:0] CNT_ONE = DW'(1);

  state_t        state, state_nx;
  logic [MW-1:0] m_nx, stop_r, stop_nx, step_r, step_nx;
  logic [DW-1:0] cnt, cnt_nx, dwl_r, dwl_nx;
  logic          dir_up, dir_nx, set_nx, en_nx, busy_nx, done_nx;
  logic [MW:0]   stepped;
`ifdef SWEEP_PINGPONG_EN
  logic [MW-1:0] org_r, org_nx;
  logic [MW:0]   turned;
`endif

  // Returns {hit, word}: hit means the target was reached or would be overshot,
  // in which case the word saturates at the target.
  function automatic logic [MW:0] step_word(input logic [MW-1:0] cur, input logic [MW-1:0] stp,
                                            input logic [MW-1:0] tgt, input logic up);
    logic [MW:0] sum;
    logic        hit;
    sum = {1'b0, cur} + {1'b0, stp};
    if (up) hit = sum[MW] || (sum[MW-1:0] >= tgt) || (stp == '0);
    else    hit = (stp > cur) || ((cur - stp) <= tgt) || (stp == '0);
    if (hit)     return {1'b1, tgt};
    else if (up) return {1'b0, sum[MW-1:0]};
    else         return {1'b0, cur - stp};
  endfunction

  always_comb begin
    state_nx = state;
    m_nx     = dds_m;
    set_nx   = 1'b0;
    en_nx    = dds_en;
    busy_nx  = busy;
    done_nx  = 1'b0;
    cnt_nx   = cnt;
    stop_nx  = stop_r;
    step_nx  = step_r;
    dwl_nx   = dwl_r;
    dir_nx   = dir_up;
    stepped  = step_word(dds_m, step_r, stop_r, dir_up);
`ifdef SWEEP_PINGPONG_EN
    org_nx   = org_r;
    turned   = step_word(dds_m, step_r, org_r, ~dir_up);
`endif
    case (state)
      IDLE: begin
        if (start && !abort) begin
          stop_nx  = f_stop;
          step_nx  = f_step;
          dwl_nx   = (dwell == '0) ? CNT_ONE : dwell;
          dir_nx   = (f_stop >= f_start);
          m_nx     = f_start;
          set_nx   = 1'b1;
          en_nx    = 1'b1;
          busy_nx  = 1'b1;
          cnt_nx   = (dwell == '0) ? CNT_ONE : dwell;
          state_nx = (f_start == f_stop) ? FINAL : DWELL;
`ifdef SWEEP_PINGPONG_EN
          org_nx   = f_start;
`endif
        end
      end
      DWELL: begin
        if (cnt == CNT_ONE) begin
          cnt_nx = dwl_r;
          m_nx   = stepped[MW-1:0];
          if (stepped[MW]) state_nx = FINAL;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      FINAL: begin
        if (cnt == CNT_ONE) begin
          done_nx = 1'b1;
`ifdef SWEEP_PINGPONG_EN
          // Turn around: the old start becomes the target and stepping resumes at once.
          stop_nx  = org_r;
          org_nx   = stop_r;
          dir_nx   = ~dir_up;
          cnt_nx   = dwl_r;
          m_nx     = turned[MW-1:0];
          state_nx = turned[MW] ? FINAL : DWELL;
`else
          busy_nx  = 1'b0;
          en_nx    = 1'b0;
          cnt_nx   = '0;
          state_nx = IDLE;
`endif
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // Abort overrides everything; the last word stays on dds_m.
    if (abort && state != IDLE) begin
      state_nx = IDLE;
      m_nx     = dds_m;
      set_nx   = 1'b0;
      en_nx    = 1'b0;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dds_m   <= '0;
      dds_set <= 1'b0;
      dds_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      stop_r  <= '0;
      step_r  <= '0;
      dwl_r   <= '0;
      dir_up  <= 1'b0;
`ifdef SWEEP_PINGPONG_EN
      org_r   <= '0;
`endif
    end else begin
      state   <= state_nx;
      dds_m   <= m_nx;
      dds_set <= set_nx;
      dds_en  <= en_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      cnt     <= cnt_nx;
      stop_r  <= stop_nx;
      step_r  <= step_nx;
      dwl_r   <= dwl_nx;
      dir_up  <= dir_nx;
`ifdef SWEEP_PINGPONG_EN
      org_r   <= org_nx;
`endif
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: a spec-level sweep model fills a queue of
// per-cycle expected outputs that is drained against the DUT every cycle.
module tb_dds_sweep_ctrl;
  localparam int MW = 40;
  localparam int DW = 24;

  typedef struct packed {
    logic [MW-1:0] m;
    logic          set;
    logic          en;
    logic          busy;
    logic          done;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [MW-1:0] f_start, f_stop, f_step;
  logic [DW-1:0] dwell;
  logic [MW-1:0] dds_m;
  logic          dds_set, dds_en, busy, done;

  obs_t q[$];
  int   vecs = 0;
  int   errs = 0;

  dds_sweep_ctrl #(.MW(MW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .dds_m(dds_m), .dds_set(dds_set), .dds_en(dds_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(logic [MW-1:0] m, logic s, logic e, logic b, logic d);
    obs_t o;
    o.m = m; o.set = s; o.en = e; o.busy = b; o.done = d;
    return o;
  endfunction

  task automatic chk(input string tag, input obs_t exp);
    obs_t got;
    got = mk(dds_m, dds_set, dds_en, busy, done);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got m=%0d set=%0b en=%0b busy=%0b done=%0b, expected m=%0d set=%0b en=%0b busy=%0b done=%0b",
             tag, got.m, got.set, got.en, got.busy, got.done, exp.m, exp.set, exp.en, exp.busy, exp.done);
    end
  endtask

  // Expected per-cycle outputs of a full sweep, first entry = cycle after start.
  function automatic void build(logic [MW-1:0] fs, logic [MW-1:0] ft, logic [MW-1:0] st, logic [DW-1:0] dw);
    logic signed [MW+1:0] w, nx, s, t;
    int  d;
    bit  up, first;
    d     = (dw == 0) ? 1 : int'(dw);
    up    = (ft >= fs);
    w     = $signed({2'b00, fs});
    s     = $signed({2'b00, st});
    t     = $signed({2'b00, ft});
    first = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < d; i++) begin
        q.push_back(mk(w[MW-1:0], first, 1'b1, 1'b1, 1'b0));
        first = 1'b0;
      end
      if (w == t) break;
      nx = up ? w + s : w - s;
      if (st == 0 || (up && nx >= t) || (!up && nx <= t)) nx = t;
      w = nx;
    end
    q.push_back(mk(ft, 1'b0, 1'b0, 1'b0, 1'b1));
    q.push_back(mk(ft, 1'b0, 1'b0, 1'b0, 1'b0));
  endfunction

  task automatic run(input string tag, input logic [MW-1:0] fs, input logic [MW-1:0] ft,
                     input logic [MW-1:0] st, input logic [DW-1:0] dw,
                     input int ign_at, input int abort_at, input int rst_at, input bit scramble);
    obs_t exp;
    int   k;
    q.delete();
    build(fs, ft, st, dw);
    @(negedge clk);
    f_start = fs; f_stop = ft; f_step = st; dwell = dw; start = 1'b1;
    k = 1;
    while (q.size() > 0) begin
      @(negedge clk);
      exp = q.pop_front();
      chk(tag, exp);
      if (scramble && k == 1) begin
        f_start = MW'($urandom); f_stop = MW'($urandom); f_step = MW'($urandom); dwell = DW'($urandom);
      end
      start = (k == ign_at);
      abort = (k == abort_at);
      if (k == abort_at) begin
        q.delete();
        q.push_back(mk(exp.m, 1'b0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(exp.m, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      if (k == rst_at) begin
        #1 rst_n = 1'b0;
        #1 chk({tag, "_async"}, mk('0, 1'b0, 1'b0, 1'b0, 1'b0));
        #1 rst_n = 1'b1;
        q.delete();
        q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      k++;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    repeat (2) @(negedge clk);
    chk("reset", mk('0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_idle", mk('0, 1'b0, 1'b0, 1'b0, 1'b0));

    run("up",           40'd1000, 40'd1300, 40'd100, 24'd4, -1, -1, -1, 1'b0);
    run("up_ign_start", 40'd1000, 40'd1300, 40'd100, 24'd4,  3, -1, -1, 1'b0);
    run("up_abort",     40'd1000, 40'd1300, 40'd100, 24'd4, -1,  6, -1, 1'b0);
    run("down_sat",     40'd1300, 40'd1000, 40'd200, 24'd2, -1, -1, -1, 1'b1);
    run("edge_top",     40'hFF_FFFF_FFCE, 40'hFF_FFFF_FFFF, 40'd100, 24'd1, -1, -1, -1, 1'b0);
    run("step_zero",    40'd40315426, 40'd80630853, 40'd0, 24'd3, -1, -1, -1, 1'b0);
    run("down_big",     40'd350, 40'd100, 40'd300, 24'd1, -1, -1, -1, 1'b0);
    run("same_dw0",     40'd500, 40'd500, 40'd7, 24'd0, -1, -1, -1, 1'b0);

    // start and abort together while idle: nothing happens
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", mk(40'd500, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    chk("start_abort_idle2", mk(40'd500, 1'b0, 1'b0, 1'b0, 1'b0));

    run("rst_mid",      40'd1000, 40'd1300, 40'd100, 24'd4, -1, -1,  7, 1'b0);
    run("up_after_rst", 40'd1000, 40'd1300, 40'd100, 24'd4, -1, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer that drives the tuning-word/enable/set interface of the 40-bit DDS core at 12 MHz. It performs a linear frequency sweep from a start word to a stop word in fixed increments, holding each word for a programmable dwell. Phase is reset only at sweep start; later steps are phase-continuous. It sits between the host/config logic and the DDS instance and replaces hand-driven m/set/en sequencing.

Parameters:
MW, 40, tuning-word width (matches DDS accumulator)
DW, 24, dwell counter width (2^24 cycles ≈ 1.4 s at 12 MHz)

Ports:
clk  in  1  system clock (12 MHz)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a sweep when idle
abort  in  1  level/pulse; terminates any sweep
f_start  in  MW  first tuning word
f_stop  in  MW  final tuning word (may be above or below f_start)
f_step  in  MW  unsigned increment magnitude
dwell  in  DW  cycles each word is held; 0 treated as 1
dds_m  out  MW  tuning word to DDS m
dds_set  out  1  one-cycle phase-reset pulse to DDS set
dds_en  out  1  DDS enable
busy  out  1  high while sweeping
done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; dds_m=0, dds_set=0, dds_en=0, busy=0, done=0, counter=0. Reset mid-sweep aborts immediately with these values.
- All outputs registered. States: IDLE, DWELL, FINAL.
- IDLE: start=1 at edge N -> latch f_start/f_stop/f_step/dwell; dir_up = (f_stop >= f_start). At N+1: dds_m=f_start, dds_set=1 (this cycle only), dds_en=1, busy=1, counter=max(dwell,1); go DWELL (or FINAL if f_start==f_stop).
- DWELL: counter decrements each cycle. On the cycle counter==1, the next word is loaded and the counter reloads, so each word is held exactly max(dwell,1) cycles.
  - Up: sum = dds_m + f_step computed MW+1 bits wide. If carry, or sum >= f_stop, or f_step==0: dds_m=f_stop and go FINAL. Otherwise dds_m=sum.
  - Down: if f_step > dds_m, or dds_m - f_step <= f_stop, or f_step==0: dds_m=f_stop and go FINAL. Otherwise dds_m -= f_step.
  - Saturates at f_stop, never overshoots it.
- FINAL: hold f_stop for max(dwell,1) cycles. On expiry: done=1 for one cycle, busy=0, dds_en=0, dds_m holds f_stop, go IDLE.
- abort=1 in any non-IDLE state -> next cycle IDLE, busy=0, dds_en=0, dds_set=0, dds_m holds its value, no done. abort has priority over start and over step updates in the same cycle.
- start while busy: ignored. start and abort together in IDLE: abort wins, start ignored.
- Inputs other than start/abort are sampled only at start. Changes during a sweep have no effect.
- dds_set is never asserted except on the first cycle of a sweep.

Optional Feature:
Macro SWEEP_PINGPONG_EN.
- Defined: on expiry of the FINAL dwell, the block does not go IDLE. It swaps endpoints (new target = original f_start), inverts dir_up, pulses done for one cycle, keeps dds_en=1 and busy=1, and continues stepping from the current word with no dds_set. This repeats indefinitely until abort or reset.
- Not defined: single-pass behaviour as above. No pingpong logic synthesised.

Test Plan:
- Up sweep: f_start=1000, f_stop=1300, f_step=100, dwell=4, start at cycle 0 -> cycle 1: dds_set=1, dds_en=1, dds_m=1000 for cycles 1-4, 1100 for 5-8, 1200 for 9-12, 1300 for 13-16; done=1 at cycle 17; busy=0 and dds_en=0 from cycle 17.
- Down sweep with saturation: f_start=1300, f_stop=1000, f_step=200, dwell=2 -> dds_m sequence 1300, 1100, 1000, 2 cycles each; done one cycle after the last 1000 cycle.
- Edge words: f_start=2^40-50, f_stop=2^40-1, f_step=100, dwell=1 -> dds_m goes to 2^40-1 with no wrap to a small value. Separately, f_step=0 with f_start=40315426, f_stop=80630853 -> jump to 80630853 after the first dwell, then done.
- abort at cycle 6 of the up-sweep case -> cycle 7: busy=0, dds_en=0, dds_m=1100, no done pulse. A start at cycle 3 of an active sweep is ignored (sequence unchanged).
- rst_n driven low mid-sweep asynchronously -> all outputs 0 immediately, without waiting for a clk edge. After release, start behaves as in the up-sweep case.
- SWEEP_PINGPONG_EN defined, up-sweep params -> 1000 ... 1300, then 1200, 1100, 1000, then 1100 ... Each turnaround gives one done pulse. dds_set occurs only at cycle 1. Sweep runs until abort.
